// File: rtl/adder_pkg.sv
// Shared types and constants for the limb-serial adder.
// LIMB_W matches the existing 10-bit adder datapath.
package adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int LIMB_W = 10;

    // Counter must be able to represent MAX_LIMBS itself.
    function automatic int cnt_width(input int max_limbs);
        return $clog2(max_limbs + 1);
    endfunction

endpackage

// File: rtl/limb_add_cin.sv
// Combinational WIDTH-bit add with carry-in; result is {cout, sum}.
module limb_add_cin #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH:0]   res_o
);

    // Extend before adding so the carry is never truncated.
    assign res_o = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/limb_serial_adder.sv
// Multi-precision adder: operand limbs arrive LSB-first on a valid/ready stream,
// the carry is held between beats, and each beat yields one registered sum limb.
module limb_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH     = LIMB_W,
    parameter int MAX_LIMBS = 8,
    parameter int CNT_W     = cnt_width(MAX_LIMBS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_first,
    input  logic             i_last,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_last,
    output logic             o_err,
    output logic             o_valid,
    input  logic             i_ready
);

    state_e           state_q, state_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             new_op;
    logic             cin;
    logic [WIDTH:0]   add_res;
    logic [CNT_W-1:0] cnt_nxt;
    logic             len_err;
    logic             proto_err;
    logic             op_end;

    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready;

    // A beat in IDLE always starts a new operation, flagged or not.
    assign new_op    = (state_q == IDLE) || i_first;
    assign cin       = new_op ? 1'b0 : carry_q;
    assign proto_err = i_first ? (state_q == BUSY) : (state_q == IDLE);
    assign cnt_nxt   = new_op ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign len_err   = !i_last && (cnt_nxt == CNT_W'(MAX_LIMBS));
    assign op_end    = i_last || len_err;

    limb_add_cin #(.WIDTH(WIDTH)) u_add (
        .a_i   (i_add_term1),
        .b_i   (i_add_term2),
        .cin_i (cin),
        .res_o (add_res)
    );

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        last_d  = last_q;
        err_d   = err_q;
        valid_d = valid_q;
        if (accept) begin
            carry_d = add_res[WIDTH];
            sum_d   = add_res[WIDTH-1:0];
            cout_d  = op_end ? add_res[WIDTH] : 1'b0;
            last_d  = op_end;
            err_d   = proto_err || len_err;
            valid_d = 1'b1;
            if (op_end) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = BUSY;
                cnt_d   = cnt_nxt;
            end
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            last_q  <= last_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign o_sum   = sum_q;
    assign o_cout  = cout_q;
    assign o_last  = last_q;
    assign o_err   = err_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_limb_serial_adder.sv
// Directed bench for limb_serial_adder: expected beats go into a scoreboard
// queue when accepted and are checked as the DUT hands them off.
module tb_limb_serial_adder;

    localparam int W = 10;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         last;
        logic         err;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic         first, last, in_valid;
    logic         o_ready;
    logic [W-1:0] o_sum;
    logic         o_cout, o_last, o_err, o_valid;
    logic         out_ready;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    limb_serial_adder #(.WIDTH(W), .MAX_LIMBS(8), .CNT_W(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_add_term1 (a),
        .i_add_term2 (b),
        .i_first     (first),
        .i_last      (last),
        .i_valid     (in_valid),
        .o_ready     (o_ready),
        .o_sum       (o_sum),
        .o_cout      (o_cout),
        .o_last      (o_last),
        .o_err       (o_err),
        .o_valid     (o_valid),
        .i_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: a handoff is committed at the next rising edge when valid&ready at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_valid && out_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_beat: got sum=%0d cout=%0b last=%0b err=%0b, none expected",
                       o_sum, o_cout, o_last, o_err);
            end else begin
                e = sb.pop_front();
                assert ({o_sum, o_cout, o_last, o_err} === {e.sum, e.cout, e.last, e.err}) else begin
                    n_fail++;
                    $error("FAIL out_beat: got sum=%0d cout=%0b last=%0b err=%0b, want sum=%0d cout=%0b last=%0b err=%0b",
                           o_sum, o_cout, o_last, o_err, e.sum, e.cout, e.last, e.err);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic f, input logic l,
                        input logic [W-1:0] es, input logic ec, input logic el, input logic ee);
        exp_t e;
        bit   ok;
        a = ta; b = tb; first = f; last = l; in_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $error("FAIL accept_timeout: got o_ready=0 want 1");
        end else begin
            e.sum = es; e.cout = ec; e.last = el; e.err = ee;
            sb.push_back(e);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; a = '0; b = '0; first = 0; last = 0; in_valid = 0; out_ready = 1'b1;
        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_sum", o_sum, 0);
        chk("rst_flags", {o_cout, o_last, o_err}, 0);
        chk("rst_ready", o_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Two-limb carry chain
        send(10'd1023, 10'd1, 1, 0, 10'd0, 0, 0, 0);
        send(10'd0,    10'd0, 0, 1, 10'd1, 0, 1, 0);
        drain();

        // Single limb: visible one cycle after accept
        send(10'd600, 10'd500, 1, 1, 10'd76, 1, 1, 0);
        chk("single_latency_valid", o_valid, 1);
        chk("single_latency_sum", o_sum, 76);
        drain();

        // Backpressure in the middle of a 3-limb chain
        out_ready = 1'b0;
        send(10'd1023, 10'd1, 1, 0, 10'd0, 0, 0, 0);
        a = 10'd1023; b = 10'd1; first = 0; last = 0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", o_ready, 0);
            chk("bp_valid", o_valid, 1);
            chk("bp_sum", o_sum, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(10'd1023, 10'd1, 0, 0, 10'd1, 0, 0, 0);
        send(10'd1023, 10'd1, 0, 1, 10'd1, 1, 1, 0);
        drain();

        // Protocol error: i_first while busy with carry pending
        send(10'd1023, 10'd1, 1, 0, 10'd0, 0, 0, 0);
        send(10'd5,    10'd5, 1, 0, 10'd10, 0, 0, 1);
        send(10'd7,    10'd8, 0, 1, 10'd15, 0, 1, 0);
        drain();

        // Length error on the 8th limb, then a stray limb lands in IDLE
        send(10'd1023, 10'd1, 1, 0, 10'd0, 0, 0, 0);
        for (int i = 0; i < 6; i++) send(10'd1023, 10'd1, 0, 0, 10'd1, 0, 0, 0);
        send(10'd1023, 10'd1, 0, 0, 10'd1, 1, 1, 1);
        send(10'd2,    10'd3, 0, 1, 10'd5, 0, 1, 1);
        drain();

        // Reset in the middle of a 4-limb operation
        send(10'd1023, 10'd1, 1, 0, 10'd0, 0, 0, 0);
        send(10'd1023, 10'd1, 0, 0, 10'd1, 0, 0, 0);
        chk("pre_reset_valid", o_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", o_valid, 0);
        chk("mid_reset_sum", o_sum, 0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        send(10'd3, 10'd4, 1, 1, 10'd7, 0, 1, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
